// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
//
// Two-register MMIO window at mmio_base_addr:
//   +0 TXDATA (write pushes value[7:0] into the TX FIFO)
//   +4 STATUS (reads back via r_data; writes are acknowledged and dropped)
//
// Ports:
//   clock                           system clock, rising-edge active
//   reset                           asynchronous reset, active low
//   memory_mapped_io_control        write request (enable, addr, value, width)
//   memory_mapped_io_r_data         registered STATUS word
//   memory_mapped_io_write_complete one-cycle acknowledge of an accepted write
//   uart_tx                         serial line, idle high

package mmio_uart_tx_pkg;
  parameter int unsigned XLEN = 32;

  typedef struct packed {
    logic            enable;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [1:0]      width;
  } mem_write_control_t;
endpackage

module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] mmio_base_addr = 32'h00030000,
  parameter int unsigned clocks_per_bit = 434,
  parameter int unsigned fifo_depth     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  mem_write_control_t memory_mapped_io_control,
  output logic [XLEN-1:0]    memory_mapped_io_r_data,
  output logic               memory_mapped_io_write_complete,
  output logic               uart_tx
);

  localparam int unsigned PtrW  = $clog2(fifo_depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(clocks_per_bit);

  localparam logic [BaudW-1:0] BaudReload = BaudW'(clocks_per_bit - 1);
  localparam logic [CntW-1:0]  CntFull    = CntW'(fifo_depth);

  typedef enum logic [1:0] {AccIdle, AccAck, AccWaitRelease} acc_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // Bits of the request that do not influence behaviour (width is ignored on purpose).
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{memory_mapped_io_control.width,
                              memory_mapped_io_control.value[XLEN-1:8],
                              memory_mapped_io_control.addr[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit;
  logic sel_status;

  assign hit = memory_mapped_io_control.enable &&
               (memory_mapped_io_control.addr[31:3] == mmio_base_addr[31:3]);
  assign sel_status = memory_mapped_io_control.addr[2];

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_mem_q [fifo_depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_head;
  logic            push;
  logic            pop;

  // Flags come from the registered count, so a push into a full FIFO is refused
  // even when the transmitter pops in the same cycle.
  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Write handshake FSM
  // ---------------------------------------------------------------------------
  acc_state_e acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    push  = 1'b0;
    unique case (acc_q)
      AccIdle: begin
        if (hit) begin
          if (sel_status) begin
            acc_d = AccAck;
          end else if (!fifo_full) begin
            push  = 1'b1;
            acc_d = AccAck;
          end
        end
      end
      AccAck: acc_d = AccWaitRelease;
      // Waiting for enable to drop keeps a long-held store from pushing twice.
      AccWaitRelease: begin
        if (!memory_mapped_io_control.enable) acc_d = AccIdle;
      end
      default: acc_d = AccIdle;
    endcase
  end

  assign memory_mapped_io_write_complete = (acc_q == AccAck);

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_e       tx_q, tx_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;

  always_comb begin
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (tx_q)
      TxIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = BaudReload;
          tx_d    = TxStart;
        end
      end
      TxStart: begin
        if (baud_q == '0) begin
          baud_d    = BaudReload;
          bit_idx_d = 3'd0;
          tx_d      = TxData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TxData: begin
        if (baud_q == '0) begin
          baud_d  = BaudReload;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            tx_d = TxStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TxStop: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            baud_d  = BaudReload;
            tx_d    = TxStart;
          end else begin
            tx_d = TxIdle;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: tx_d = TxIdle;
    endcase
  end

  // The line is registered from the next state so uart_tx is glitch-free yet
  // changes in the same cycle as the state it belongs to.
  always_comb begin
    unique case (tx_d)
      TxStart: line_d = 1'b0;
      TxData:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  assign uart_tx = line_q;

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // STATUS word
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] status;

  always_comb begin
    status       = '0;
    status[0]    = fifo_full;
    status[1]    = fifo_empty;
    status[2]    = (tx_q != TxIdle);
    status[11:8] = 4'(count_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q                   <= AccIdle;
      tx_q                    <= TxIdle;
      baud_q                  <= '0;
      bit_idx_q               <= 3'd0;
      shift_q                 <= 8'h00;
      line_q                  <= 1'b1;
      wr_ptr_q                <= '0;
      rd_ptr_q                <= '0;
      count_q                 <= '0;
      memory_mapped_io_r_data <= XLEN'(32'h00000002);
    end else begin
      acc_q                   <= acc_d;
      tx_q                    <= tx_d;
      baud_q                  <= baud_d;
      bit_idx_q               <= bit_idx_d;
      shift_q                 <= shift_d;
      line_q                  <= line_d;
      wr_ptr_q                <= wr_ptr_d;
      rd_ptr_q                <= rd_ptr_d;
      count_q                 <= count_d;
      memory_mapped_io_r_data <= status;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= memory_mapped_io_control.value[7:0];
  end

endmodule
